lc4_divider_seq: RTL

//   Iterative unsigned divider serving the LC4 DIV and MOD instructions. It sits

---
 rtl/lc4_defs.sv | 14 +
 rtl/lc4_div_step.sv | 25 ++
 rtl/lc4_divider_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/lc4_defs.sv
// rtl/lc4_defs.sv - shared LC4 execute-stage definitions for the divider and ALU result mux
package lc4_defs;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  // Sub-opcode fields that steer the ALU result mux onto o_quotient / o_remainder
  localparam logic [2:0] LC4_SUBOP_DIV = 3'b011;
  localparam logic [1:0] LC4_SUBOP_MOD = 2'b11;

endpackage

// File: rtl/lc4_div_step.sv
// rtl/lc4_div_step.sv - one combinational restoring-division iteration
module lc4_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // WIDTH+1 bit compare: the borrow out of the subtract is the "does not fit" flag
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = ~diff[WIDTH];
    rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/lc4_divider_seq.sv
// rtl/lc4_divider_seq.sv - iterative unsigned divider for LC4 DIV/MOD, one bit per cycle
module lc4_divider_seq
  import lc4_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  divState_t      state, nextState;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] remReg, quoReg, divReg;
  logic [WIDTH-1:0] remNext, quoNext;
  logic           divZero;
  logic           accept, stepEn, finish;

  lc4_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (remReg),
    .quo_in (quoReg),
    .divisor(divReg),
    .rem_out(remNext),
    .quo_out(quoNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    stepEn    = 1'b0;
    finish    = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          nextState = DIV_RUN;
        end
      end
      DIV_RUN: begin
        stepEn = 1'b1;
        if (count == LAST) begin
          finish    = 1'b1;
          nextState = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (i_start) begin
          accept    = 1'b1;
          nextState = DIV_RUN;
        end else begin
          nextState = DIV_IDLE;
        end
      end
      default: nextState = DIV_IDLE;
    endcase
  end

  // quoReg starts as the dividend and is shifted out MSB-first while quotient bits shift in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remReg      <= '0;
      quoReg      <= '0;
      divReg      <= '0;
      divZero     <= 1'b0;
      count       <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (accept) begin
      remReg  <= '0;
      quoReg  <= i_dividend;
      divReg  <= i_divisor;
      divZero <= (i_divisor == '0);
      count   <= '0;
    end else if (stepEn) begin
      remReg <= remNext;
      quoReg <= quoNext;
      count  <= count + CW'(1);
      if (finish) begin
        o_quotient  <= divZero ? '0 : quoNext;
        o_remainder <= divZero ? '0 : remNext;
      end
    end
  end

  assign o_busy  = (state == DIV_RUN);
  assign o_valid = (state == DIV_DONE);

endmodule
